// File: rtl/priority_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : priority_arbiter_if
//  Description : Request/grant bundle between the requesters (master side)
//                and the fixed-priority arbiter (slave side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface priority_arbiter_if #(
  parameter int N    = 8,
  parameter int IDXW = 3
);

  logic            en;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_vld;

  // Requester side: drives enable and requests, observes the grant.
  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_vld
  );

  // Arbiter side: observes enable and requests, drives the grant.
  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_vld
  );

endinterface
`default_nettype wire

// File: rtl/priority_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : priority_arbiter
//  Description : Sequential fixed-priority arbiter for N requesters. Bit N-1
//                has the highest priority. The owner keeps the registered
//                one-hot grant until it drops its request or en falls; no
//                preemption. Owners are always separated by one idle cycle.
//  Option      : define ARB_TIMEOUT_EN to bound ownership to MAX_HOLD cycles
//                and mask the timed-out owner for the next arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module priority_arbiter #(
  parameter int N        = 8,
  parameter int IDXW     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  priority_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  // MAX_HOLD must fit the 8-bit hold counter and allow at least two cycles.
  if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_max_hold_range_err
    $error("priority_arbiter: MAX_HOLD out of range 2..255");
  end

  state_t          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            vld_q, vld_d;

  // Candidate vector and the winner selected from it.
  logic [N-1:0]    pick;
  logic [IDXW-1:0] sel_idx;
  logic            sel_any;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0]   hold_q, hold_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] elig;

  // Masked requester is skipped unless it is the only one asking.
  always_comb begin
    elig = bus.req & ~mask_q;
    pick = (|elig) ? elig : bus.req;
  end
`else
  // No timeout: every active request is a candidate.
  always_comb begin
    pick = bus.req;
  end
`endif

  // Priority encoder: the highest set bit of pick wins.
  always_comb begin
    sel_idx = '0;
    sel_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) begin
        sel_idx = IDXW'(i);
        sel_any = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/GRANT machine.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
`ifdef ARB_TIMEOUT_EN
    hold_d  = hold_q;
    mask_d  = mask_q;
`endif
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        idx_d = '0;
        vld_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        // The mask applies to one arbitration only, granted or not.
        mask_d = '0;
`endif
        if (bus.en && sel_any) begin
          state_d = S_GRANT;
          gnt_d   = N'(1) << sel_idx;
          idx_d   = sel_idx;
          vld_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_d  = 8'd0;
`endif
        end
      end
      S_GRANT: begin
        if (!bus.en || !bus.req[idx_q]) begin
          // Normal release: owner dropped its request or arbiter disabled.
          state_d = S_IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          vld_d   = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          // Forced release after MAX_HOLD cycles; remember who it was.
          state_d = S_IDLE;
          gnt_d   = '0;
          idx_d   = '0;
          vld_d   = 1'b0;
          mask_d  = gnt_q;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Hold counter and one-shot mask registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= 8'd0;
      mask_q <= '0;
    end else begin
      hold_q <= hold_d;
      mask_q <= mask_d;
    end
  end
`endif

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = idx_q;
  assign bus.gnt_vld = vld_q;

endmodule
`default_nettype wire
